// File: rtl/key_debounce.sv
// key_debounce: single-key input conditioner.
//
// Synchronises a raw, bouncy mechanical key into the system clock domain,
// debounces both edges and produces a clean pressed level plus single-cycle
// event pulses for press, release, short click and long press.
//
// Parameters
//   P_CLK_FREQ_KHZ  clock frequency in kHz (cycles per ms)
//   P_DEBOUNCE_MS   debounce window in ms; N_DB = P_CLK_FREQ_KHZ * P_DEBOUNCE_MS (>= 1)
//   P_LONG_MS       long-press threshold in ms from the press pulse;
//                   N_LONG = P_CLK_FREQ_KHZ * P_LONG_MS (> N_DB)
//   P_KEY_ACTIVE    i_key level meaning "pressed" (0 = active-low key)
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_key        raw key pin (asynchronous, bouncy)
//   o_key_level  debounced pressed level (1 = pressed), registered
//   o_press      one-cycle pulse when a press is confirmed
//   o_release    one-cycle pulse when a release is confirmed
//   o_short      one-cycle pulse with o_release when no long press fired
//   o_long       one-cycle pulse after N_LONG held cycles, at most once per press
module key_debounce #(
    parameter int unsigned P_CLK_FREQ_KHZ = 5000,
    parameter int unsigned P_DEBOUNCE_MS  = 20,
    parameter int unsigned P_LONG_MS      = 1000,
    parameter bit          P_KEY_ACTIVE   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_key_level,
    output logic o_press,
    output logic o_release,
    output logic o_short,
    output logic o_long
);

    localparam int unsigned N_DB   = P_CLK_FREQ_KHZ * P_DEBOUNCE_MS;
    localparam int unsigned N_LONG = P_CLK_FREQ_KHZ * P_LONG_MS;
    localparam int unsigned DB_W   = $clog2(N_DB + 1);
    localparam int unsigned LONG_W = $clog2(N_LONG + 1);

    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(N_DB);
    localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(N_LONG);
    localparam logic [LONG_W-1:0] LONG_ONE = LONG_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StPressChk,
        StHeld,
        StRelChk
    } state_e;

    // ------------------------------------------------------------------
    // Two-flop synchroniser, reset to the inactive key level so that a
    // key held through reset is seen as a fresh press afterwards.
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic act;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= ~P_KEY_ACTIVE;
            sync2_q <= ~P_KEY_ACTIVE;
        end else begin
            sync1_q <= i_key;
            sync2_q <= sync1_q;
        end
    end

    assign act = (sync2_q == P_KEY_ACTIVE);

    // ------------------------------------------------------------------
    // Debounce / hold FSM state
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic [LONG_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               long_done_q, long_done_d;

    logic               level_q, level_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               short_q, short_d;
    logic               long_q, long_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            short_q     <= short_d;
            long_q      <= long_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        short_d     = 1'b0;
        long_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                db_cnt_d   = '0;
                hold_cnt_d = '0;
                if (act) begin
                    state_d  = StPressChk;
                    db_cnt_d = DB_ONE;
                end
            end

            StPressChk: begin
                if (!act) begin
                    state_d  = StIdle;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_MAX) begin
                    state_d     = StHeld;
                    press_d     = 1'b1;
                    db_cnt_d    = '0;
                    hold_cnt_d  = '0;
                    long_done_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end

            StHeld: begin
                // The cycle that leaves for StRelChk still counts as held;
                // only cycles spent in StRelChk are excluded from the hold.
                if (hold_cnt_q != LONG_MAX) begin
                    hold_cnt_d = hold_cnt_q + LONG_ONE;
                    if ((hold_cnt_q == LONG_MAX - LONG_ONE) && !long_done_q) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end
                end
                if (!act) begin
                    state_d  = StRelChk;
                    db_cnt_d = DB_ONE;
                end
            end

            StRelChk: begin
                if (act) begin
                    // Bounce while held: resume holding, hold count untouched.
                    state_d  = StHeld;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_MAX) begin
                    state_d    = StIdle;
                    release_d  = 1'b1;
                    short_d    = !long_done_q;
                    db_cnt_d   = '0;
                    hold_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end

            default: begin
                state_d  = StIdle;
                db_cnt_d = '0;
            end
        endcase

        level_d = (state_d == StHeld) || (state_d == StRelChk);
    end

    assign o_key_level = level_q;
    assign o_press     = press_q;
    assign o_release   = release_q;
    assign o_short     = short_q;
    assign o_long      = long_q;

endmodule
